// File: rtl/nibble_key_stream.sv
// rtl/nibble_key_stream.sv - Galois-LFSR keystream sequencer feeding a 4-bit XOR stage
// One key nibble per accepted data nibble; single-entry valid/ready output register.
module nibble_key_stream #(
    parameter int                SEED_W = 16,
    parameter logic [SEED_W-1:0] TAPS   = 16'hB400,
    parameter int                CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic              i_seed_load,
    input  logic [SEED_W-1:0] i_seed,
    output logic              o_seed_err,
    input  logic              i_in_valid,
    input  logic [3:0]        i_in_data,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic [3:0]        o_xor_word,
    output logic [3:0]        o_xor_key,
    input  logic [3:0]        i_xor_out,
    output logic              o_out_valid,
    output logic [3:0]        o_out_data,
    output logic              o_out_last,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_word_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEED_W-1:0]   r_lfsr;
    logic [SEED_W-1:0]   w_lfsr_step;
    logic                r_out_valid;
    logic [3:0]          r_out_data;
    logic                r_out_last;
    logic                r_seed_err;
    logic [CNT_W-1:0]    r_word_cnt;
    logic                w_accept;
    logic                w_out_take;
    logic                w_seed_ok;
    logic                w_seed_bad;

    assign w_seed_ok   = (r_state == ST_IDLE) && i_seed_load && (i_seed != '0);
    assign w_seed_bad  = (r_state == ST_IDLE) && i_seed_load && (i_seed == '0);
    assign o_in_ready  = (r_state == ST_RUN) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_out_take  = r_out_valid && i_out_ready;
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

    assign o_xor_word  = i_in_data;
    assign o_xor_key   = r_lfsr[3:0];
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_seed_err  = r_seed_err;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_word_cnt  = r_word_cnt;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_seed_ok)               w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && i_in_last)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_take)              w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_lfsr      <= SEED_W'(1);
            r_out_valid <= 1'b0;
            r_out_data  <= 4'h0;
            r_out_last  <= 1'b0;
            r_seed_err  <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_seed_err <= w_seed_bad;
            if (w_seed_ok) begin
                r_lfsr     <= i_seed;
                r_word_cnt <= '0;
            end
            // An accept in the same cycle as a downstream take simply reloads the register.
            if (w_accept) begin
                r_out_data  <= i_xor_out;
                r_out_last  <= i_in_last;
                r_out_valid <= 1'b1;
                r_lfsr      <= w_lfsr_step;
                if (!(&r_word_cnt)) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
            end else if (w_out_take) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
